// File: rtl/alu_op_sequencer.sv
// Single-issue micro-sequencer that drives cpu_top's register file and 74181 ALU controls.
// Optional carry chaining (ADC/SBC from flag_c) is enabled by defining ALU_SEQ_CARRY_CHAIN_EN.
module alu_op_sequencer #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_REGS   = 8,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [3:0]            instr_comm,
   input  logic                  instr_mode,
   input  logic                  instr_cin,
   input  logic                  instr_bsel,
   input  logic [ADDR_WIDTH-1:0] instr_ra,
   input  logic [ADDR_WIDTH-1:0] instr_rb,
   input  logic [ADDR_WIDTH-1:0] instr_rd,
   input  logic [DATA_WIDTH-1:0] instr_imm,
   input  logic                  instr_wb,
   input  logic                  instr_use_carry,
   output logic [ADDR_WIDTH-1:0] reg_read_addr1,
   output logic [ADDR_WIDTH-1:0] reg_read_addr2,
   output logic                  reg_write_enable,
   output logic [ADDR_WIDTH-1:0] reg_write_addr,
   output logic [DATA_WIDTH-1:0] reg_write_data,
   output logic [3:0]            alu_comm,
   output logic                  alu_mode,
   output logic                  alu_cin,
   output logic                  b_source_sel,
   output logic [DATA_WIDTH-1:0] alu_b_imm,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_cout,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  flag_c,
   output logic                  flag_z
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t state;
   logic   wb_q;
   logic   eff_cin;
   logic   accept;

   // Logical carry-in before the 74181 active-low inversion
`ifdef ALU_SEQ_CARRY_CHAIN_EN
   assign eff_cin = instr_use_carry ? flag_c : instr_cin;
`else
   logic unused_use_carry;
   assign unused_use_carry = instr_use_carry;
   assign eff_cin          = instr_cin;
`endif

   assign accept         = instr_valid && instr_ready;
   assign reg_write_data = result;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= S_IDLE;
         instr_ready      <= 1'b1;
         busy             <= 1'b0;
         done             <= 1'b0;
         wb_q             <= 1'b0;
         reg_read_addr1   <= '0;
         reg_read_addr2   <= '0;
         reg_write_addr   <= '0;
         reg_write_enable <= 1'b0;
         alu_comm         <= 4'd0;
         alu_mode         <= 1'b0;
         alu_cin          <= 1'b1;
         b_source_sel     <= 1'b0;
         alu_b_imm        <= '0;
         result           <= '0;
         flag_c           <= 1'b0;
         flag_z           <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  reg_read_addr1 <= instr_ra;
                  reg_read_addr2 <= instr_rb;
                  reg_write_addr <= instr_rd;
                  alu_comm       <= instr_comm;
                  alu_mode       <= instr_mode;
                  alu_cin        <= ~eff_cin;
                  b_source_sel   <= instr_bsel;
                  alu_b_imm      <= instr_imm;
                  wb_q           <= instr_wb;
                  instr_ready    <= 1'b0;
                  busy           <= 1'b1;
                  state          <= S_EXEC;
               end
            end
            // ALU has settled for a full cycle on the latched controls
            S_EXEC: begin
               result           <= alu_result;
               flag_z           <= (alu_result == '0);
               flag_c           <= alu_mode ? 1'b0 : alu_cout;
               reg_write_enable <= wb_q;
               done             <= 1'b1;
               state            <= S_WB;
            end
            S_WB: begin
               reg_write_enable <= 1'b0;
               instr_ready      <= 1'b1;
               busy             <= 1'b0;
               state            <= S_IDLE;
            end
            default: begin
               reg_write_enable <= 1'b0;
               instr_ready      <= 1'b1;
               busy             <= 1'b0;
               state            <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: models cpu_top (register file + 74181) around the DUT
// and checks every instruction against an instruction-level reference model.
module tb_alu_op_sequencer;

   localparam int DW = 16;
   localparam int NR = 8;
   localparam int AW = 3;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
   localparam bit CHAIN = 1'b1;
`else
   localparam bit CHAIN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]    comm;
      logic          mode;
      logic          cin;
      logic          bsel;
      logic [AW-1:0] ra;
      logic [AW-1:0] rb;
      logic [AW-1:0] rd;
      logic [DW-1:0] imm;
      logic          wb;
      logic          uc;
   } ins_t;

   logic clk = 1'b0;
   logic reset;
   logic instr_valid, instr_ready;
   logic [3:0] instr_comm;
   logic instr_mode, instr_cin, instr_bsel, instr_wb, instr_use_carry;
   logic [AW-1:0] instr_ra, instr_rb, instr_rd;
   logic [DW-1:0] instr_imm;
   logic [AW-1:0] reg_read_addr1, reg_read_addr2, reg_write_addr;
   logic reg_write_enable;
   logic [DW-1:0] reg_write_data, alu_b_imm, alu_result, result;
   logic [3:0] alu_comm;
   logic alu_mode, alu_cin, b_source_sel, alu_cout, busy, done, flag_c, flag_z;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_comm(instr_comm), .instr_mode(instr_mode), .instr_cin(instr_cin),
      .instr_bsel(instr_bsel), .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_rd(instr_rd),
      .instr_imm(instr_imm), .instr_wb(instr_wb), .instr_use_carry(instr_use_carry),
      .reg_read_addr1(reg_read_addr1), .reg_read_addr2(reg_read_addr2),
      .reg_write_enable(reg_write_enable), .reg_write_addr(reg_write_addr),
      .reg_write_data(reg_write_data), .alu_comm(alu_comm), .alu_mode(alu_mode),
      .alu_cin(alu_cin), .b_source_sel(b_source_sel), .alu_b_imm(alu_b_imm),
      .alu_result(alu_result), .alu_cout(alu_cout), .busy(busy), .done(done),
      .result(result), .flag_c(flag_c), .flag_z(flag_z)
   );

   // 74181 function table with active-high data and logical carry-in c; bit 16 is carry-out
   function automatic logic [16:0] alu181(input logic [3:0] s, input logic m, input logic c,
                                          input logic [15:0] a, input logic [15:0] b);
      logic [15:0] nb, x, y, f;
      nb = ~b;
      if (m) begin
         case (s)
            4'd0:  f = ~a;
            4'd1:  f = ~(a | b);
            4'd2:  f = ~a & b;
            4'd3:  f = 16'h0000;
            4'd4:  f = ~(a & b);
            4'd5:  f = nb;
            4'd6:  f = a ^ b;
            4'd7:  f = a & nb;
            4'd8:  f = ~a | b;
            4'd9:  f = ~(a ^ b);
            4'd10: f = b;
            4'd11: f = a & b;
            4'd12: f = 16'hFFFF;
            4'd13: f = a | nb;
            4'd14: f = a | b;
            default: f = a;
         endcase
         return {1'b0, f};
      end
      case (s)
         4'd0:  begin x = a;      y = 16'h0000; end
         4'd1:  begin x = a | b;  y = 16'h0000; end
         4'd2:  begin x = a | nb; y = 16'h0000; end
         4'd3:  begin x = 16'hFFFF; y = 16'h0000; end
         4'd4:  begin x = a;      y = a & nb;   end
         4'd5:  begin x = a | b;  y = a & nb;   end
         4'd6:  begin x = a;      y = nb;       end
         4'd7:  begin x = a & nb; y = 16'hFFFF; end
         4'd8:  begin x = a;      y = a & b;    end
         4'd9:  begin x = a;      y = b;        end
         4'd10: begin x = a | nb; y = a & b;    end
         4'd11: begin x = a & b;  y = 16'hFFFF; end
         4'd12: begin x = a;      y = a;        end
         4'd13: begin x = a | b;  y = a;        end
         4'd14: begin x = a | nb; y = a;        end
         default: begin x = a;    y = 16'hFFFF; end
      endcase
      return {1'b0, x} + {1'b0, y} + {16'h0000, c};
   endfunction

   // cpu_top stand-in: register file written by the DUT, ALU fed from DUT controls
   logic [DW-1:0] rf [NR];
   logic env_clear;
   logic [16:0] env_alu;

   always @(posedge clk) begin
      if (env_clear) begin
         for (int i = 0; i < NR; i++) rf[i] <= '0;
      end else if (reg_write_enable) begin
         rf[reg_write_addr] <= reg_write_data;
      end
   end

   always_comb begin
      env_alu    = alu181(alu_comm, alu_mode, ~alu_cin, rf[reg_read_addr1],
                          b_source_sel ? alu_b_imm : rf[reg_read_addr2]);
      alu_result = env_alu[15:0];
      alu_cout   = env_alu[16];
   end

   // Reference model state at instruction granularity
   logic [DW-1:0] m_rf [NR];
   logic m_c, m_z;

   function automatic ins_t mk(input logic [3:0] comm, input logic mode, input logic cin,
                               input logic bsel, input logic [2:0] ra, input logic [2:0] rb,
                               input logic [2:0] rd, input logic [15:0] imm, input logic wb,
                               input logic uc);
      ins_t i;
      i.comm = comm; i.mode = mode; i.cin = cin; i.bsel = bsel;
      i.ra = ra; i.rb = rb; i.rd = rd; i.imm = imm; i.wb = wb; i.uc = uc;
      return i;
   endfunction

   task automatic drive(input ins_t i);
      instr_comm = i.comm; instr_mode = i.mode; instr_cin = i.cin; instr_bsel = i.bsel;
      instr_ra = i.ra; instr_rb = i.rb; instr_rd = i.rd; instr_imm = i.imm;
      instr_wb = i.wb; instr_use_carry = i.uc;
   endtask

   task automatic model_eval(input ins_t i, output logic [16:0] r, output logic effc);
      effc = (CHAIN && i.uc) ? m_c : i.cin;
      r = alu181(i.comm, i.mode, effc, m_rf[i.ra], i.bsel ? i.imm : m_rf[i.rb]);
   endtask

   task automatic model_commit(input ins_t i, input logic [16:0] r);
      m_z = (r[15:0] == 16'h0000);
      m_c = i.mode ? 1'b0 : r[16];
      if (i.wb) m_rf[i.rd] = r[15:0];
   endtask

   task automatic run_instr(input ins_t i, input string tag);
      logic [16:0] r;
      logic effc, ec, ez;
      int n;
      @(negedge clk);
      drive(i);
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (instr_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s accept_timeout: instr_ready=%b required 1", tag, instr_ready);
         instr_valid = 1'b0;
         return;
      end
      model_eval(i, r, effc);
      ec = i.mode ? 1'b0 : r[16];
      ez = (r[15:0] == 16'h0000);
      @(negedge clk);
      instr_valid = 1'b0;
      tests++;
      if ({instr_ready, busy, done, reg_write_enable} !== 4'b0100) begin
         fails++;
         $display("FAIL %s exec_status: rdy/busy/done/we=%b required 0100", tag,
                  {instr_ready, busy, done, reg_write_enable});
      end
      tests++;
      if ({reg_read_addr1, reg_read_addr2, alu_comm, alu_mode, alu_cin, b_source_sel, alu_b_imm}
          !== {i.ra, i.rb, i.comm, i.mode, ~effc, i.bsel, i.imm}) begin
         fails++;
         $display("FAIL %s exec_controls: got %h required %h", tag,
                  {reg_read_addr1, reg_read_addr2, alu_comm, alu_mode, alu_cin, b_source_sel, alu_b_imm},
                  {i.ra, i.rb, i.comm, i.mode, ~effc, i.bsel, i.imm});
      end
      @(negedge clk);
      tests++;
      if ({done, busy, instr_ready, reg_write_enable, reg_write_addr, reg_write_data, result, flag_c, flag_z}
          !== {1'b1, 1'b1, 1'b0, i.wb, i.rd, r[15:0], r[15:0], ec, ez}) begin
         fails++;
         $display("FAIL %s wb_cycle: done/busy/rdy/we/addr/data/res/c/z got %h required %h", tag,
                  {done, busy, instr_ready, reg_write_enable, reg_write_addr, reg_write_data, result, flag_c, flag_z},
                  {1'b1, 1'b1, 1'b0, i.wb, i.rd, r[15:0], r[15:0], ec, ez});
      end
      model_commit(i, r);
      @(negedge clk);
      tests++;
      if ({done, busy, instr_ready, reg_write_enable, alu_comm, reg_write_addr, result}
          !== {1'b0, 1'b0, 1'b1, 1'b0, i.comm, i.rd, r[15:0]}) begin
         fails++;
         $display("FAIL %s idle_hold: got %h required %h", tag,
                  {done, busy, instr_ready, reg_write_enable, alu_comm, reg_write_addr, result},
                  {1'b0, 1'b0, 1'b1, 1'b0, i.comm, i.rd, r[15:0]});
      end
      tests++;
      if (rf[i.rd] !== m_rf[i.rd]) begin
         fails++;
         $display("FAIL %s regfile r%0d: got %h required %h", tag, i.rd, rf[i.rd], m_rf[i.rd]);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; env_clear = 1'b1; instr_valid = 1'b0;
      drive(mk(4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0));
      for (int k = 0; k < NR; k++) m_rf[k] = '0;
      m_c = 1'b0; m_z = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({instr_ready, busy, done, reg_write_enable, reg_read_addr1, reg_read_addr2, reg_write_addr,
           reg_write_data, alu_comm, alu_mode, alu_cin, b_source_sel, alu_b_imm, result, flag_c, flag_z}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0,
               1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_values: got %h required %h",
                  {instr_ready, busy, done, reg_write_enable, reg_read_addr1, reg_read_addr2, reg_write_addr,
                   reg_write_data, alu_comm, alu_mode, alu_cin, b_source_sel, alu_b_imm, result, flag_c, flag_z},
                  {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0,
                   1'b0, 1'b0});
      end
      reset = 1'b0; env_clear = 1'b0;
   endtask

   task automatic test_directed;
      run_instr(mk(4'b1010, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 3'd1, 16'h1234, 1'b1, 1'b0), "loadi_r1");
      run_instr(mk(4'b1010, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 3'd2, 16'h5678, 1'b1, 1'b0), "loadi_r2");
      run_instr(mk(4'b1001, 1'b0, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b1, 1'b0), "add_cin0");
      tests++;
      if ({rf[3], flag_c} !== {16'h68AC, 1'b0}) begin
         fails++;
         $display("FAIL add_cin0_value: r3/c=%h required %h", {rf[3], flag_c}, {16'h68AC, 1'b0});
      end
      run_instr(mk(4'b1001, 1'b0, 1'b1, 1'b0, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b1, 1'b0), "add_cin1");
      tests++;
      if (rf[3] !== 16'h68AD) begin
         fails++;
         $display("FAIL add_cin1_value: r3=%h required 68ad", rf[3]);
      end
   endtask

   task automatic test_overflow;
      run_instr(mk(4'b1010, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 3'd4, 16'hFFFF, 1'b1, 1'b0), "loadi_r4");
      run_instr(mk(4'b1001, 1'b0, 1'b0, 1'b1, 3'd4, 3'd0, 3'd4, 16'h0001, 1'b1, 1'b0), "ovf_add");
      tests++;
      if ({result, flag_c, flag_z} !== {16'h0000, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL ovf_flags: res/c/z=%h required %h", {result, flag_c, flag_z}, {16'h0000, 1'b1, 1'b1});
      end
      run_instr(mk(4'b1011, 1'b1, 1'b0, 1'b1, 3'd1, 3'd0, 3'd1, 16'h0000, 1'b0, 1'b0), "and_nowb");
      tests++;
      if ({rf[1], flag_c, flag_z} !== {16'h1234, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL and_nowb_state: r1/c/z=%h required %h", {rf[1], flag_c, flag_z}, {16'h1234, 1'b0, 1'b1});
      end
   endtask

   task automatic test_carry_chain;
      logic [15:0] want;
      want = CHAIN ? 16'h0001 : 16'h0000;
      run_instr(mk(4'b1010, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 3'd4, 16'hFFFF, 1'b1, 1'b0), "chain_load");
      run_instr(mk(4'b1001, 1'b0, 1'b0, 1'b1, 3'd4, 3'd0, 3'd4, 16'h0001, 1'b1, 1'b0), "chain_ovf");
      run_instr(mk(4'b1001, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd5, 16'h0000, 1'b1, 1'b1), "chain_adc");
      tests++;
      if (rf[5] !== want) begin
         fails++;
         $display("FAIL chain_adc_value: r5=%h required %h", rf[5], want);
      end
   endtask

   task automatic test_back_to_back;
      ins_t i1, i2;
      logic [16:0] r1, r2;
      logic e1, e2;
      i1 = mk(4'b1010, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 3'd6, 16'hA5A5, 1'b1, 1'b0);
      i2 = mk(4'b1001, 1'b0, 1'b1, 1'b1, 3'd6, 3'd0, 3'd7, 16'h0101, 1'b1, 1'b0);
      @(negedge clk);
      drive(i1);
      instr_valid = 1'b1;
      model_eval(i1, r1, e1);
      @(negedge clk);
      drive(i2);
      tests++;
      if ({instr_ready, busy} !== 2'b01) begin
         fails++;
         $display("FAIL b2b_exec1: rdy/busy=%b required 01", {instr_ready, busy});
      end
      @(negedge clk);
      tests++;
      if ({instr_ready, done, reg_write_enable, reg_write_addr, reg_write_data}
          !== {1'b0, 1'b1, 1'b1, i1.rd, r1[15:0]}) begin
         fails++;
         $display("FAIL b2b_wb1: got %h required %h", {instr_ready, done, reg_write_enable, reg_write_addr, reg_write_data},
                  {1'b0, 1'b1, 1'b1, i1.rd, r1[15:0]});
      end
      model_commit(i1, r1);
      model_eval(i2, r2, e2);
      @(negedge clk);
      tests++;
      if ({instr_ready, busy, done} !== 3'b100) begin
         fails++;
         $display("FAIL b2b_idle: rdy/busy/done=%b required 100", {instr_ready, busy, done});
      end
      @(negedge clk);
      instr_valid = 1'b0;
      tests++;
      if ({instr_ready, busy, alu_comm, alu_cin} !== {1'b0, 1'b1, i2.comm, ~e2}) begin
         fails++;
         $display("FAIL b2b_accept2: got %h required %h", {instr_ready, busy, alu_comm, alu_cin},
                  {1'b0, 1'b1, i2.comm, ~e2});
      end
      @(negedge clk);
      tests++;
      if ({done, reg_write_enable, reg_write_addr, reg_write_data} !== {1'b1, 1'b1, i2.rd, r2[15:0]}) begin
         fails++;
         $display("FAIL b2b_wb2: got %h required %h", {done, reg_write_enable, reg_write_addr, reg_write_data},
                  {1'b1, 1'b1, i2.rd, r2[15:0]});
      end
      model_commit(i2, r2);
      @(negedge clk);
      tests++;
      if ({rf[6], rf[7]} !== {16'hA5A5, 16'hA6A7}) begin
         fails++;
         $display("FAIL b2b_regs: r6/r7=%h required a5a5a6a7", {rf[6], rf[7]});
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] old6;
      int bad;
      old6 = m_rf[6];
      run_instr(mk(4'b1001, 1'b0, 1'b0, 1'b1, 3'd4, 3'd0, 3'd4, 16'h0000, 1'b1, 1'b0), "pre_zero");
      @(negedge clk);
      drive(mk(4'b1010, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 3'd6, 16'hBEEF, 1'b1, 1'b0));
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      reset = 1'b1;
      #1;
      tests++;
      if ({instr_ready, busy, done, reg_write_enable, flag_c, flag_z, result, alu_cin, alu_comm}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 4'h0}) begin
         fails++;
         $display("FAIL reset_mid_async: got %h required %h",
                  {instr_ready, busy, done, reg_write_enable, flag_c, flag_z, result, alu_cin, alu_comm},
                  {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 4'h0});
      end
      m_c = 1'b0; m_z = 1'b0;
      bad = 0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (reg_write_enable || done) bad++;
      end
      tests++;
      if ({bad, rf[6]} !== {32'd0, old6}) begin
         fails++;
         $display("FAIL reset_mid_discard: stray/r6=%0d/%h required 0/%h", bad, rf[6], old6);
      end
      run_instr(mk(4'b1001, 1'b0, 1'b1, 1'b0, 3'd1, 3'd2, 3'd6, 16'h0000, 1'b1, 1'b0), "post_reset");
   endtask

   task automatic test_random;
      ins_t i;
      for (int n = 0; n < 40; n++) begin
         i = mk(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                3'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         run_instr(i, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_overflow();
      test_carry_chain();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Single-issue micro-sequencer in front of cpu_top (8x16 register file plus 74181-slice ALU).
- Accepts one decoded ALU instruction per valid/ready handshake and drives the datapath control inputs. Captures the ALU result and flags, then writes the result back to the register file.
- Lets a host or a future fetch unit run register-to-register ALU programs without hand-toggling datapath controls.

Parameters:
- DATA_WIDTH, 16, datapath width; must match cpu_top.
- NUM_REGS, 8, register count; must match cpu_top.
- ADDR_WIDTH, $clog2(NUM_REGS), register address width (derived).

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  sequencer can accept.
- instr_comm  input  4  74181 S3..S0 select.
- instr_mode  input  1  0=Math, 1=Logic.
- instr_cin  input  1  logical carry-in, active-high (1 = add one).
- instr_bsel  input  1  0=register B, 1=immediate.
- instr_ra  input  ADDR_WIDTH  A operand register.
- instr_rb  input  ADDR_WIDTH  B operand register.
- instr_rd  input  ADDR_WIDTH  destination register.
- instr_imm  input  DATA_WIDTH  immediate B value.
- instr_wb  input  1  1=write result to rd; 0=flags only (compare/test).
- instr_use_carry  input  1  take carry-in from flag_c (see Optional Feature).
- reg_read_addr1, reg_read_addr2  output  ADDR_WIDTH  to cpu_top.
- reg_write_enable  output  1  to cpu_top.
- reg_write_addr  output  ADDR_WIDTH  to cpu_top.
- reg_write_data  output  DATA_WIDTH  to cpu_top.
- alu_comm  output  4  to cpu_top.
- alu_mode  output  1  to cpu_top.
- alu_cin  output  1  to cpu_top; active-low 74181 Cn.
- b_source_sel  output  1  to cpu_top.
- alu_b_imm  output  DATA_WIDTH  to cpu_top.
- alu_result  input  DATA_WIDTH  from cpu_top.
- alu_cout  input  1  from cpu_top; active-high carry-out.
- busy  output  1  high outside IDLE.
- done  output  1  one-cycle pulse in WB.
- result  output  DATA_WIDTH  last captured result.
- flag_c, flag_z  output  1  carry and zero flags of last instruction.

Behaviour:
- States and transitions:
  - IDLE: instr_ready=1. Handshake (valid & ready) latches all instr_* fields and moves to EXEC.
  - EXEC: drives latched controls for one full cycle so the combinational ALU settles. At the end of the cycle, captures alu_result into result and alu_cout/zero into the flags. Moves to WB.
  - WB: reg_write_enable = instr_wb, reg_write_addr = rd, reg_write_data = result. done=1 for exactly this cycle. Returns to IDLE.
- Throughput and latency:
  - One instruction per 3 cycles.
  - Write occurs on the rising edge that ends WB, 2 cycles after the accept edge.
- Control outputs hold the latched values from EXEC through WB and keep them in IDLE until the next accept. This lets the bench observe them after done.
- Carry mapping:
  - alu_cin = ~effective_cin in both modes, where effective_cin = instr_cin (or flag_c, see Optional Feature).
  - Instructions use logical carry; only this block knows the 74181 inversion.
- Flags:
  - flag_z = (alu_result == 0).
  - flag_c = alu_cout when mode=Math; forced 0 when mode=Logic.
  - Flags update even when instr_wb=0.
- instr_ready=0 in EXEC and WB. A valid held across those cycles is neither consumed nor lost; it is accepted on the first IDLE cycle.
- rd equal to ra or rb is legal: reads complete in EXEC, before the write in WB.
- Reset values: state=IDLE, instr_ready=1, all addresses/data/imm/comm=0, alu_mode=0, b_source_sel=0, alu_cin=1 (no carry), reg_write_enable=0, busy=0, done=0, result=0, flag_c=0, flag_z=0.
- Reset asserted mid-instruction:
  - Outputs go to reset values immediately (asynchronous); reg_write_enable drops within the same cycle.
  - The pending instruction is discarded, with no write and no done.

Optional Feature:
- Macro: ALU_SEQ_CARRY_CHAIN_EN.
- Defined: when instr_use_carry=1, effective_cin = flag_c (ADC/SBC chaining for multi-word arithmetic); otherwise instr_cin.
- Undefined: instr_use_carry is ignored and effective_cin = instr_cin always. The port remains so the interface is identical in both builds.

Test Plan:
- LOADI r1: comm=1010, mode=1, bsel=1, imm=0x1234, wb=1 -> accept edge N; EXEC at N+1; WB at N+2 with reg_write_enable=1, addr=1, data=0x1234; done pulse; flag_z=0, flag_c=0.
- ADD r3=r1+r2 (r2 loaded 0x5678): comm=1001, mode=0, cin=0, bsel=0 -> alu_cin=1; r3=0x68AC; flag_c=0. Repeat with cin=1 -> 0x68AD.
- Overflow: r4=0xFFFF, add imm 0x0001, cin=0 -> result 0x0000, flag_c=1, flag_z=1. Then wb=0 AND (comm=1011, mode=1) with imm 0x0000 -> no write enable, flag_z=1, flag_c=0, done pulses.
- Back-to-back: instr_valid held high with two instructions -> instr_ready low for 2 cycles; second accepted exactly 3 cycles after the first; both writes land in order.
- Reset during EXEC -> reg_write_enable never asserts; no done; flags=0; target register unchanged. Next instruction after reset executes normally.
- With ALU_SEQ_CARRY_CHAIN_EN: after the overflow case (flag_c=1), add r0(=0)+imm 0 with use_carry=1 -> result 0x0001. Without the macro -> 0x0000.
